// File: rtl/alu_defs.sv
// Shared ALU writeback definitions.
// Flag bit positions and entry layout.
package alu_defs;

  localparam int FLAG_CF = 0;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 3;

  localparam int FLAGS_W = 4;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 3;

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [FLAGS_W-1:0] flags;
    logic [REG_W-1:0]   dst;
    logic               wr_reg;
    logic               wr_flags;
  } alu_entry_t;

  localparam int ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and full/empty tracking
// for a power-of-two circular queue.
module sync_fifo_ctrl #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_idx,
  output logic [AW-1:0] rd_idx,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count
);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;

  // Next pointers; flush discards any push/pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  assign wr_idx = wr_q[AW-1:0];
  assign rd_idx = rd_q[AW-1:0];
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[PW-1] != rd_q[PW-1]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count  = wr_q - rd_q;

endmodule

// File: rtl/alu_wb_queue.sv
// In-order writeback queue between the ALU
// and the register-file write port.
module alu_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_result,
  input  logic [alu_defs::FLAGS_W-1:0] in_flags,
  input  logic [REG_W-1:0]             in_dst,
  input  logic                         in_wr_reg,
  input  logic                         in_wr_flags,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [DATA_W-1:0]            wb_data,
  output logic [REG_W-1:0]             wb_dst,
  output logic [alu_defs::FLAGS_W-1:0] flags_q,
  output logic [CW-1:0]                count
);

  import alu_defs::*;

  logic [DATA_W-1:0]  res_q [DEPTH];
  logic [FLAGS_W-1:0] flg_q [DEPTH];
  logic [REG_W-1:0]   dst_q [DEPTH];
  logic               wrr_q [DEPTH];
  logic               wrf_q [DEPTH];

  logic [AW-1:0]      wr_idx, rd_idx;
  logic               full, empty;
  logic               push, pop;
  logic [FLAGS_W-1:0] flags_d;

  sync_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .wr_idx (wr_idx),
    .rd_idx (rd_idx),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  // in_ready looks only at occupancy, never at wb_ready.
  assign in_ready = !full;
  assign push     = in_valid && !full && !flush;

  // Non-writing heads retire without waiting on the regfile.
  assign wb_valid = !empty && wrr_q[rd_idx];
  assign pop      = !empty && !flush &&
                    (wrr_q[rd_idx] ? wb_ready : 1'b1);
  assign wb_data  = res_q[rd_idx];
  assign wb_dst   = dst_q[rd_idx];

  // Entry storage written at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_idx] <= in_result;
      flg_q[wr_idx] <= in_flags;
      dst_q[wr_idx] <= in_dst;
      wrr_q[wr_idx] <= in_wr_reg;
      wrf_q[wr_idx] <= in_wr_flags;
    end
  end

  // Flags follow retirement order.
  always_comb begin
    flags_d = flags_q;
    if (pop && wrf_q[rd_idx]) flags_d = flg_q[rd_idx];
  end

  // Architectural flags register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

endmodule

// File: tb/tb_alu_wb_queue.sv
// Bench for alu_wb_queue: scoreboard of
// register writes plus directed flag checks.
module tb_alu_wb_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [2:0]  in_dst;
  logic        in_wr_reg;
  logic        in_wr_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [2:0]  wb_dst;
  logic [3:0]  flags_q;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  dst;
  } exp_t;

  exp_t sb[$];

  alu_wb_queue dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_flags    (in_flags),
    .in_dst      (in_dst),
    .in_wr_reg   (in_wr_reg),
    .in_wr_flags (in_wr_flags),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_dst      (wb_dst),
    .flags_q     (flags_q),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs are stable at negedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (wb_valid && wb_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected data=%h dst=%0d",
                     wb_data, wb_dst);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (wb_data !== e.data || wb_dst !== e.dst) begin
              bad++;
              $display("FAIL sb_order got=%h/%0d exp=%h/%0d",
                       wb_data, wb_dst, e.data, e.dst);
            end
          end
        end
        if (in_valid && in_ready && in_wr_reg) begin
          exp_t e;
          e.data = in_result;
          e.dst  = in_dst;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] r,
                       input logic [3:0] f,
                       input logic [2:0] d,
                       input logic wr, input logic wf);
    in_valid    = 1'b1;
    in_result   = r;
    in_flags    = f;
    in_dst      = d;
    in_wr_reg   = wr;
    in_wr_flags = wf;
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    n = 0;
    while (count != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL drain_timeout count=%0d exp=0", count);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick();
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL rst_count got=%0d exp=0", count);
    end
    total++;
    if (flags_q !== 4'b0000) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=0000", flags_q);
    end
    total++;
    if (wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_wbv got=%b exp=0", wb_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_rdy got=%b exp=1", in_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single;
    wb_ready = 1'b1;
    drive(32'hDEADBEEF, 4'b0110, 3'd3, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF ||
        wb_dst !== 3'd3) begin
      bad++;
      $display("FAIL single_wb got=%b/%h/%0d exp=1/deadbeef/3",
               wb_valid, wb_data, wb_dst);
    end
    tick();
    total++;
    if (flags_q !== 4'b0110) begin
      bad++;
      $display("FAIL single_flags got=%b exp=0110", flags_q);
    end
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL single_count got=%0d exp=0", count);
    end
  endtask

  task automatic test_fill_drain;
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h1000 + i, 4'hF, 3'(i + 1), 1'b1, 1'b0);
      tick();
    end
    total++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full got=%0d/%b exp=4/0",
               count, in_ready);
    end
    drive(32'h5555, 4'h0, 3'd7, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd4) begin
      bad++;
      $display("FAIL fifth_push got=%0d exp=4", count);
    end
    repeat (2) tick();
    total++;
    if (wb_data !== 32'h1000 || wb_dst !== 3'd1) begin
      bad++;
      $display("FAIL stall_stable got=%h/%0d exp=1000/1",
               wb_data, wb_dst);
    end
    total++;
    if (flags_q !== 4'b0110) begin
      bad++;
      $display("FAIL fill_flags got=%b exp=0110", flags_q);
    end
    drain(20);
  endtask

  task automatic test_full_pushpop;
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h2000 + i, 4'h0, 3'(i), 1'b1, 1'b0);
      tick();
    end
    drive(32'h2FFF, 4'h0, 3'd6, 1'b1, 1'b0);
    wb_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_ready = 1'b0;
    total++;
    if (count !== 3'd3) begin
      bad++;
      $display("FAIL full_pp_count got=%0d exp=3", count);
    end
    total++;
    if (wb_data !== 32'h2001) begin
      bad++;
      $display("FAIL full_pp_head got=%h exp=2001", wb_data);
    end
    drain(20);
  endtask

  task automatic test_flags_only;
    wb_ready = 1'b0;
    drive(32'h3333, 4'b0101, 3'd5, 1'b1, 1'b0);
    tick();
    drive(32'h0, 4'b1001, 3'd0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    total++;
    if (flags_q !== 4'b0110 || count !== 3'd2) begin
      bad++;
      $display("FAIL fo_stall got=%b/%0d exp=0110/2",
               flags_q, count);
    end
    wb_ready = 1'b1;
    tick();
    total++;
    if (flags_q !== 4'b0110 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL fo_head got=%b/%b exp=0110/0",
               flags_q, wb_valid);
    end
    tick();
    total++;
    if (flags_q !== 4'b1001 || count !== 3'd0) begin
      bad++;
      $display("FAIL fo_retire got=%b/%0d exp=1001/0",
               flags_q, count);
    end
  endtask

  task automatic test_flush;
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h4000 + i, 4'b1111, 3'(i), 1'b1, 1'b1);
      tick();
    end
    drive(32'h4444, 4'b1111, 3'd4, 1'b1, 1'b1);
    wb_ready = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (count !== 3'd0 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_q got=%0d/%b exp=0/0",
               count, wb_valid);
    end
    total++;
    if (flags_q !== 4'b1001) begin
      bad++;
      $display("FAIL flush_flags got=%b exp=1001", flags_q);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_rdy got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_back_to_back;
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(32'h6000 + i, 4'(i), 3'(7 - i), 1'b1, 1'b1);
      tick();
      if (i > 0) begin
        total++;
        if (count !== 3'd1 || flags_q !== 4'(i - 1)) begin
          bad++;
          $display("FAIL b2b_%0d got=%0d/%b exp=1/%b",
                   i, count, flags_q, 4'(i - 1));
        end
      end
    end
    drain(10);
  endtask

  task automatic test_async_reset;
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h7000 + i, 4'b0111, 3'(i), 1'b1, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (flags_q !== 4'b0111 || count !== 3'd1) begin
      bad++;
      $display("FAIL ar_pre got=%b/%0d exp=0111/1",
               flags_q, count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (count !== 3'd0 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL ar_queue got=%0d/%b exp=0/0",
               count, wb_valid);
    end
    total++;
    if (flags_q !== 4'b0000) begin
      bad++;
      $display("FAIL ar_flags got=%b exp=0000", flags_q);
    end
    sb.delete();
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_result   = '0;
    in_flags    = '0;
    in_dst      = '0;
    in_wr_reg   = 1'b0;
    in_wr_flags = 1'b0;
    wb_ready    = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pushpop();
    test_flags_only();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
